// File: rtl/branch_update_scheduler_pkg.sv
// Shared definitions for the gshare update scheduler: default widths, queue entry
// layout and FSM state encoding.
package branch_update_scheduler_pkg;

    localparam int DERINLIK_VARSAYILAN   = 4;
    localparam int ADRES_BIT_VARSAYILAN  = 5;
    localparam int GECMIS_BIT_VARSAYILAN = 5;
    localparam int YON_BIT               = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } durum_t;

    // Queue entry at the default widths; the top rebuilds it from its own parameters.
    typedef struct packed {
        logic [ADRES_BIT_VARSAYILAN-1:0]  adres;
        logic                             yon;
        logic [GECMIS_BIT_VARSAYILAN-1:0] gecmis;
    } kuyruk_girdi_t;

    function automatic int girdi_bit(input int adres_bit, input int gecmis_bit);
        return adres_bit + YON_BIT + gecmis_bit;
    endfunction

endpackage

// File: rtl/branch_queue_fifo.sv
// Synchronous in-flight branch FIFO with push, pop and a whole-queue flush.
// The head entry is presented combinationally on o_bas.
module branch_queue_fifo #(
    parameter int DERINLIK = 4,
    parameter int VERI_BIT = 11
) (
    input  logic                              i_saat,
    input  logic                              i_reset,
    input  logic                              i_ekle,
    input  logic                              i_cikar,
    input  logic                              i_temizle,
    input  logic [VERI_BIT-1:0]               i_veri,
    output logic [VERI_BIT-1:0]               o_bas,
    output logic                              o_dolu,
    output logic                              o_bos,
    output logic [$clog2(DERINLIK+1)-1:0]     o_sayi
);

    localparam int PTR_BIT  = $clog2(DERINLIK);
    localparam int SAYI_BIT = $clog2(DERINLIK+1);

    logic [VERI_BIT-1:0] bellek [DERINLIK];
    logic [PTR_BIT-1:0]  yaz_ptr;
    logic [PTR_BIT-1:0]  oku_ptr;
    logic [SAYI_BIT-1:0] sayi;
    logic                yaz;
    logic                oku;

    assign yaz = i_ekle && !o_dolu;
    assign oku = i_cikar && !o_bos;

    // NOTE: the storage array has no reset; occupancy alone decides which entries are live.
    always_ff @(posedge i_saat) begin
        if (yaz && !i_temizle)
            bellek[yaz_ptr] <= i_veri;
    end

    always_ff @(posedge i_saat) begin
        if (i_reset || i_temizle) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
            sayi    <= '0;
        end else begin
            if (yaz)
                yaz_ptr <= yaz_ptr + PTR_BIT'(1);
            if (oku)
                oku_ptr <= oku_ptr + PTR_BIT'(1);
            sayi <= sayi + SAYI_BIT'(yaz) - SAYI_BIT'(oku);
        end
    end

    assign o_dolu = (sayi == SAYI_BIT'(DERINLIK));
    assign o_bos  = (sayi == '0);
    assign o_bas  = bellek[oku_ptr];
    assign o_sayi = sayi;

endmodule

// File: rtl/branch_update_scheduler.sv
// Queues gshare predictions, matches in-order resolutions against the head and issues
// one counter update per branch, with misprediction flush and history restore.
module branch_update_scheduler
    import branch_update_scheduler_pkg::*;
#(
    parameter int DERINLIK   = DERINLIK_VARSAYILAN,
    parameter int ADRES_BIT  = ADRES_BIT_VARSAYILAN,
    parameter int GECMIS_BIT = GECMIS_BIT_VARSAYILAN
) (
    input  logic                          i_saat,
    input  logic                          i_reset,
    input  logic                          i_tahmin_gecerli,
    input  logic [ADRES_BIT-1:0]          i_tahmin_adres,
    input  logic                          i_tahmin_yon,
    input  logic [GECMIS_BIT-1:0]         i_tahmin_gecmis,
    output logic                          o_tahmin_hazir,
    input  logic                          i_cozum_gecerli,
    input  logic                          i_cozum_atladi,
    output logic                          o_cozum_hazir,
    output logic                          o_guncelle_gecerli,
    output logic [ADRES_BIT-1:0]          o_guncelle_adres,
    output logic                          o_guncelle_atladi,
    input  logic                          i_guncelle_hazir,
    output logic                          o_ongoru_yanlis,
    output logic                          o_gecmis_geri_yukle,
    output logic [GECMIS_BIT-1:0]         o_gecmis_deger,
    output logic [$clog2(DERINLIK+1)-1:0] o_dolu_sayisi
);

    localparam int GIRDI_BIT = girdi_bit(ADRES_BIT, GECMIS_BIT);

    typedef struct packed {
        logic [ADRES_BIT-1:0]  adres;
        logic                  yon;
        logic [GECMIS_BIT-1:0] gecmis;
    } girdi_t;

    durum_t                durum;
    girdi_t                yeni_girdi;
    girdi_t                bas;
    logic [GIRDI_BIT-1:0]  bas_ham;
    logic                  kuyruk_dolu;
    logic                  kuyruk_bos;
    logic                  cozum_kabul;
    logic                  yanlis;
    logic                  ekle;
    logic [GECMIS_BIT-1:0] gecmis_yeni;

    assign yeni_girdi = '{adres: i_tahmin_adres, yon: i_tahmin_yon, gecmis: i_tahmin_gecmis};
    assign bas        = girdi_t'(bas_ham);

    assign o_tahmin_hazir = !kuyruk_dolu;
    assign o_cozum_hazir  = (durum == IDLE) && !kuyruk_bos;
    assign cozum_kabul    = i_cozum_gecerli && o_cozum_hazir;
    assign yanlis         = cozum_kabul && (bas.yon != i_cozum_atladi);

    // A prediction pushed in the same cycle as a mispredict is wrong-path and is dropped.
    assign ekle = i_tahmin_gecerli && o_tahmin_hazir && !yanlis;

    // History as it should have been: the snapshot shifted by the real outcome.
    assign gecmis_yeni = (bas.gecmis << 1) | GECMIS_BIT'(i_cozum_atladi);

    branch_queue_fifo #(
        .DERINLIK (DERINLIK),
        .VERI_BIT (GIRDI_BIT)
    ) u_kuyruk (
        .i_saat    (i_saat),
        .i_reset   (i_reset),
        .i_ekle    (ekle),
        .i_cikar   (cozum_kabul),
        .i_temizle (yanlis),
        .i_veri    (yeni_girdi),
        .o_bas     (bas_ham),
        .o_dolu    (kuyruk_dolu),
        .o_bos     (kuyruk_bos),
        .o_sayi    (o_dolu_sayisi)
    );

    always_ff @(posedge i_saat) begin
        if (i_reset) begin
            durum               <= IDLE;
            o_guncelle_gecerli  <= 1'b0;
            o_guncelle_adres    <= '0;
            o_guncelle_atladi   <= 1'b0;
            o_ongoru_yanlis     <= 1'b0;
            o_gecmis_geri_yukle <= 1'b0;
            o_gecmis_deger      <= '0;
        end else begin
            o_ongoru_yanlis     <= 1'b0;
            o_gecmis_geri_yukle <= 1'b0;
            case (durum)
                IDLE: begin
                    if (cozum_kabul) begin
                        o_guncelle_gecerli <= 1'b1;
                        o_guncelle_adres   <= bas.adres;
                        o_guncelle_atladi  <= i_cozum_atladi;
                        durum              <= UPDATE;
                        if (yanlis) begin
                            o_ongoru_yanlis     <= 1'b1;
                            o_gecmis_geri_yukle <= 1'b1;
                            o_gecmis_deger      <= gecmis_yeni;
                        end
                    end
                end
                UPDATE: begin
                    // Request fields stay frozen until the table takes them.
                    if (i_guncelle_hazir) begin
                        o_guncelle_gecerli <= 1'b0;
                        durum              <= IDLE;
                    end
                end
                default: durum <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_update_scheduler.sv
// Directed and random stimulus for branch_update_scheduler, checked against a
// transaction-level queue model of the scheduling rules.
module tb_branch_update_scheduler;

    logic       i_saat = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_tahmin_gecerli = 1'b0;
    logic [4:0] i_tahmin_adres = '0;
    logic       i_tahmin_yon = 1'b0;
    logic [4:0] i_tahmin_gecmis = '0;
    logic       o_tahmin_hazir;
    logic       i_cozum_gecerli = 1'b0;
    logic       i_cozum_atladi = 1'b0;
    logic       o_cozum_hazir;
    logic       o_guncelle_gecerli;
    logic [4:0] o_guncelle_adres;
    logic       o_guncelle_atladi;
    logic       i_guncelle_hazir = 1'b0;
    logic       o_ongoru_yanlis;
    logic       o_gecmis_geri_yukle;
    logic [4:0] o_gecmis_deger;
    logic [2:0] o_dolu_sayisi;

    always #5 i_saat = ~i_saat;

    branch_update_scheduler dut (
        .i_saat              (i_saat),
        .i_reset             (i_reset),
        .i_tahmin_gecerli    (i_tahmin_gecerli),
        .i_tahmin_adres      (i_tahmin_adres),
        .i_tahmin_yon        (i_tahmin_yon),
        .i_tahmin_gecmis     (i_tahmin_gecmis),
        .o_tahmin_hazir      (o_tahmin_hazir),
        .i_cozum_gecerli     (i_cozum_gecerli),
        .i_cozum_atladi      (i_cozum_atladi),
        .o_cozum_hazir       (o_cozum_hazir),
        .o_guncelle_gecerli  (o_guncelle_gecerli),
        .o_guncelle_adres    (o_guncelle_adres),
        .o_guncelle_atladi   (o_guncelle_atladi),
        .i_guncelle_hazir    (i_guncelle_hazir),
        .o_ongoru_yanlis     (o_ongoru_yanlis),
        .o_gecmis_geri_yukle (o_gecmis_geri_yukle),
        .o_gecmis_deger      (o_gecmis_deger),
        .o_dolu_sayisi       (o_dolu_sayisi)
    );

    typedef struct {
        logic [4:0] adres;
        logic       yon;
        logic [4:0] gecmis;
    } dal_t;

    // Reference model state: in-flight branches and the expected registered outputs.
    dal_t       m_q[$];
    bit         m_known = 1'b0;
    bit         m_busy;
    logic       m_valid;
    logic [4:0] m_adres;
    logic       m_atladi;
    logic       m_yanlis;
    logic       m_geri;
    logic [4:0] m_deger;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic tg, input logic [4:0] ta,
                              input logic ty, input logic [4:0] th, input logic cg,
                              input logic ca, input logic gh);
        bit   hazir_t;
        bit   mis;
        dal_t h;
        dal_t n;
        if (rst) begin
            m_q.delete();
            m_busy = 0; m_valid = 0; m_adres = '0; m_atladi = 0;
            m_yanlis = 0; m_geri = 0; m_deger = '0;
            m_known = 1'b1;
        end else begin
            m_yanlis = 0;
            m_geri   = 0;
            mis      = 0;
            hazir_t  = (m_q.size() < 4);
            if (m_busy) begin
                if (gh) begin
                    m_busy  = 0;
                    m_valid = 0;
                end
            end else if (cg && m_q.size() != 0) begin
                h        = m_q.pop_front();
                m_busy   = 1;
                m_valid  = 1;
                m_adres  = h.adres;
                m_atladi = ca;
                if (h.yon != ca) begin
                    mis      = 1;
                    m_yanlis = 1;
                    m_geri   = 1;
                    m_deger  = {h.gecmis[3:0], ca};
                    m_q.delete();
                end
            end
            if (tg && hazir_t && !mis) begin
                n.adres = ta; n.yon = ty; n.gecmis = th;
                m_q.push_back(n);
            end
        end
    endtask

    // One clock cycle: drive, check combinational handshakes, advance, check registers.
    task automatic cycle(input logic rst, input logic tg, input logic [4:0] ta,
                         input logic ty, input logic [4:0] th, input logic cg,
                         input logic ca, input logic gh);
        i_reset          = rst;
        i_tahmin_gecerli = tg;
        i_tahmin_adres   = ta;
        i_tahmin_yon     = ty;
        i_tahmin_gecmis  = th;
        i_cozum_gecerli  = cg;
        i_cozum_atladi   = ca;
        i_guncelle_hazir = gh;
        #1;
        if (m_known) begin
            check("tahmin_hazir", o_tahmin_hazir, (m_q.size() < 4));
            check("cozum_hazir", o_cozum_hazir, (!m_busy && m_q.size() != 0));
        end
        model_step(rst, tg, ta, ty, th, cg, ca, gh);
        @(posedge i_saat);
        #1;
        check("guncelle_gecerli", o_guncelle_gecerli, m_valid);
        if (m_valid) begin
            check("guncelle_adres", o_guncelle_adres, m_adres);
            check("guncelle_atladi", o_guncelle_atladi, m_atladi);
        end
        check("ongoru_yanlis", o_ongoru_yanlis, m_yanlis);
        check("geri_yukle", o_gecmis_geri_yukle, m_geri);
        if (m_geri)
            check("gecmis_deger", o_gecmis_deger, m_deger);
        check("dolu_sayisi", o_dolu_sayisi, m_q.size());
    endtask

    task automatic idle(input logic gh);
        cycle(0, 0, '0, 0, '0, 0, 0, gh);
    endtask

    task automatic push(input logic [4:0] ta, input logic ty, input logic [4:0] th);
        cycle(0, 1, ta, ty, th, 0, 0, 1);
    endtask

    initial begin
        @(posedge i_saat);
        #1;

        // Reset held two cycles.
        cycle(1, 0, '0, 0, '0, 0, 0, 0);
        cycle(1, 0, '0, 0, '0, 0, 0, 0);
        check("rst_deger", o_gecmis_deger, 5'd0);
        check("rst_adres", o_guncelle_adres, 5'd0);
        idle(0);

        // Single correct-taken branch.
        push(5'h0A, 1, 5'b10110);
        cycle(0, 0, '0, 0, '0, 1, 1, 1);
        check("t1_adres", o_guncelle_adres, 5'h0A);
        check("t1_count", o_dolu_sayisi, 3'd0);
        idle(1);

        // Mispredict on the oldest of three flushes the rest.
        push(5'h01, 1, 5'b10110);
        push(5'h02, 0, 5'b00001);
        push(5'h03, 1, 5'b00010);
        cycle(0, 1, 5'h04, 1, 5'b11111, 1, 0, 1);
        check("t2_deger", o_gecmis_deger, 5'b01100);
        check("t2_count", o_dolu_sayisi, 3'd0);
        cycle(0, 0, '0, 0, '0, 1, 1, 1);
        cycle(0, 0, '0, 0, '0, 1, 0, 1);

        // Fill to capacity; the fifth push is dropped.
        for (int i = 0; i < 5; i++)
            push(5'(5'h10 + i), 1, 5'(i));
        check("t3_count", o_dolu_sayisi, 3'd4);

        // Backpressure on the update port, with a push accepted while in UPDATE.
        cycle(0, 0, '0, 0, '0, 1, 1, 0);
        cycle(0, 1, 5'h1F, 1, 5'h1F, 1, 1, 0);
        cycle(0, 0, '0, 0, '0, 1, 1, 0);
        cycle(0, 0, '0, 0, '0, 1, 1, 0);
        check("t4_adres_held", o_guncelle_adres, 5'h10);
        cycle(0, 0, '0, 0, '0, 1, 1, 1);
        cycle(0, 0, '0, 0, '0, 1, 1, 0);
        check("t4_next_adres", o_guncelle_adres, 5'h11);

        // Reset in the middle of an update.
        cycle(1, 0, '0, 0, '0, 0, 0, 0);
        check("t5_valid", o_guncelle_gecerli, 1'b0);
        idle(0);

        // Random traffic, including simultaneous push and pop and occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  1'($urandom),
                  5'($urandom),
                  1'($urandom),
                  5'($urandom),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom),
                  ($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
